pwm_breathe: RTL and testbench

Multi-channel LED "breathing" controller: per channel, a triangle-wave brightness ramp drives a shared free-running PWM counter. It is the parametrised successor to the single-channel fading-LED driver, adding:
- configurable width, channel count and bounds;
- hold time at each extreme;
- per-channel phase offset;
- glitch-free duty updates;
- an enable input and optional perceptual (gamma) correction.

It sits directly between the board oscillator and the LED pins.

---
 rtl/pwm_breathe.sv | 140 ++++++++++++++
 tb/tb_pwm_breathe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pwm_breathe.sv
// Multi-channel LED breathing controller: per-channel triangle ramps feed a shared PWM counter.
// Define PWM_BREATHE_GAMMA_EN to apply square-law (gamma) correction to each channel's duty.
module pwm_breathe #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 262144,
    parameter int DUTY_MIN   = 1,
    parameter int DUTY_MAX   = (1 << WIDTH) - 2,
    parameter int HOLD       = 0,
    parameter int PHASE_STEP = 0
) (
    input  logic                OSC,
    input  logic                RST_N,
    input  logic                EN,
    output logic [CHANNELS-1:0] LED,
    output logic                SYNC
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    localparam logic [WIDTH-1:0] CNT_LAST  = '1;
    localparam logic [WIDTH-1:0] LVL_MIN   = WIDTH'(DUTY_MIN);
    localparam logic [WIDTH-1:0] LVL_MAX   = WIDTH'(DUTY_MAX);
    localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD);

    typedef enum logic [1:0] {UP, HOLD_HI, DOWN, HOLD_LO} ramp_t;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic                tick;
    logic [WIDTH-1:0]    sh_q     [CHANNELS];
    logic [WIDTH-1:0]    level_q  [CHANNELS];
    logic [WIDTH-1:0]    duty_eff [CHANNELS];
    logic [HW-1:0]       hold_q   [CHANNELS];
    ramp_t               state_q  [CHANNELS];
    logic [CHANNELS-1:0] led_q;
    logic                sync_q;

    assign LED  = led_q;
    assign SYNC = sync_q;

    // Prescaler only advances while enabled, so a freeze loses no ticks.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        tick  = EN && (pre_q == PRE_LAST);
        pre_d = pre_q;
        if (EN) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

`ifdef PWM_BREATHE_GAMMA_EN
    logic [2*WIDTH-1:0] prod [CHANNELS];

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            prod[i]     = {{WIDTH{1'b0}}, level_q[i]} * {{WIDTH{1'b0}}, level_q[i]};
            duty_eff[i] = prod[i][2*WIDTH-1:WIDTH];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            duty_eff[i] = level_q[i];
        end
    end
`endif

    // Shadow duty only reloads on the last count, keeping every period glitch-free.
    always_ff @(posedge OSC or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            led_q  <= '0;
            sync_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            sync_q <= (cnt_q == CNT_LAST);
            for (int i = 0; i < CHANNELS; i++) begin
                led_q[i] <= (cnt_q < sh_q[i]);
                if (cnt_q == CNT_LAST) begin
                    sh_q[i] <= duty_eff[i];
                end
            end
        end
    end

    always_ff @(posedge OSC or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= WIDTH'(DUTY_MIN + i * PHASE_STEP);
                state_q[i] <= UP;
                hold_q[i]  <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < CHANNELS; i++) begin
                case (state_q[i])
                    UP: begin
                        if (level_q[i] < LVL_MAX) begin
                            level_q[i] <= level_q[i] + 1'b1;
                        end else begin
                            state_q[i] <= HOLD_HI;
                            hold_q[i]  <= '0;
                        end
                    end
                    HOLD_HI: begin
                        if (hold_q[i] == HOLD_LAST) begin
                            state_q[i] <= DOWN;
                        end else begin
                            hold_q[i] <= hold_q[i] + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (level_q[i] > LVL_MIN) begin
                            level_q[i] <= level_q[i] - 1'b1;
                        end else begin
                            state_q[i] <= HOLD_LO;
                            hold_q[i]  <= '0;
                        end
                    end
                    HOLD_LO: begin
                        if (hold_q[i] == HOLD_LAST) begin
                            state_q[i] <= UP;
                        end else begin
                            hold_q[i] <= hold_q[i] + 1'b1;
                        end
                    end
                    default: state_q[i] <= UP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_breathe.sv
// Bench for pwm_breathe: two instances (HOLD=0 and HOLD=3) checked per PWM period against a closed-form ramp model.
module tb_pwm_breathe;

    localparam int CH   = 2;
    localparam int W    = 4;
    localparam int PRE  = 4;
    localparam int DMIN = 1;
    localparam int DMAX = 14;
    localparam int PS   = 4;
    localparam int PER  = 1 << W;

    logic          OSC = 1'b0;
    logic          RST_N;
    logic          EN;
    logic [CH-1:0] led_a, led_b;
    logic          sync_a, sync_b;

    int checks = 0;
    int errors = 0;
    int k, en_cnt;
    int sh_a [CH];
    int sh_b [CH];
    int hi_a [CH];
    int hi_b [CH];
    int sy_a, sy_b;

    always #5 OSC = ~OSC;

    pwm_breathe #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PRE), .DUTY_MIN(DMIN),
                  .DUTY_MAX(DMAX), .HOLD(0), .PHASE_STEP(PS)) u_dut (
        .OSC(OSC), .RST_N(RST_N), .EN(EN), .LED(led_a), .SYNC(sync_a));

    pwm_breathe #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PRE), .DUTY_MIN(DMIN),
                  .DUTY_MAX(DMAX), .HOLD(3), .PHASE_STEP(PS)) u_hold (
        .OSC(OSC), .RST_N(RST_N), .EN(EN), .LED(led_b), .SYNC(sync_b));

    // Level of channel ch after n ticks: one triangle period is rise, top plateau, fall, bottom plateau.
    function automatic int tri_level(int ch, int n, int hold);
        int r, half, p;
        r    = DMAX - DMIN;
        half = r + hold + 2;
        p    = (ch * PS + n) % (2 * half);
        if (p <= r)             return DMIN + p;
        else if (p < half)      return DMAX;
        else if (p - half <= r) return DMAX - (p - half);
        else                    return DMIN;
    endfunction

    function automatic int duty(int lvl);
`ifdef PWM_BREATHE_GAMMA_EN
        return (lvl * lvl) >> W;
`else
        return lvl;
`endif
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        en_cnt = 0;
        sy_a   = 0;
        sy_b   = 0;
        for (int c = 0; c < CH; c++) begin
            sh_a[c] = 0; sh_b[c] = 0; hi_a[c] = 0; hi_b[c] = 0;
        end
    endtask

    // One clock: accumulate high-time and sync, compare at each period's end, then reload expected duty.
    task automatic step();
        logic en_s;
        @(posedge OSC);
        en_s = EN;
        #1;
        for (int c = 0; c < CH; c++) begin
            hi_a[c] += int'(led_a[c]);
            hi_b[c] += int'(led_b[c]);
        end
        if (k % PER == PER - 1) begin
            chk("sync_a_last", int'(sync_a), 1);
            chk("sync_b_last", int'(sync_b), 1);
            chk("sync_a_early", sy_a, 0);
            chk("sync_b_early", sy_b, 0);
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("hitime_a_ch%0d_k%0d", c, k), hi_a[c], sh_a[c]);
                chk($sformatf("hitime_b_ch%0d_k%0d", c, k), hi_b[c], sh_b[c]);
                sh_a[c] = duty(tri_level(c, en_cnt / PRE, 0));
                sh_b[c] = duty(tri_level(c, en_cnt / PRE, 3));
                hi_a[c] = 0;
                hi_b[c] = 0;
            end
            sy_a = 0;
            sy_b = 0;
        end else begin
            sy_a += int'(sync_a);
            sy_b += int'(sync_b);
        end
        if (en_s) en_cnt++;
        k++;
    endtask

    initial begin
        RST_N = 1'b0;
        EN    = 1'b0;
        model_reset();
        repeat (3) @(posedge OSC);
        #1;
        chk("reset_led_a", int'(led_a), 0);
        chk("reset_led_b", int'(led_b), 0);
        chk("reset_sync_a", int'(sync_a), 0);
        chk("reset_sync_b", int'(sync_b), 0);

        // First two periods frozen: dark period, then the reset levels.
        @(negedge OSC);
        RST_N = 1'b1;
        repeat (2 * PER) step();

        // Free-running ramp across several triangle periods of both instances.
        EN = 1'b1;
        repeat (40 * PER) step();

        // Freeze mid-period for 50 clocks, then resume.
        repeat (7) step();
        EN = 1'b0;
        repeat (50) step();
        EN = 1'b1;
        repeat (100) step();

        // Random enable pattern.
        repeat (30 * PER) begin
            EN = ($urandom_range(0, 3) != 0);
            step();
        end

        // Asynchronous reset part-way through a period.
        EN = 1'b1;
        while (k % PER != 3) step();
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_led_a", int'(led_a), 0);
        chk("async_led_b", int'(led_b), 0);
        chk("async_sync_a", int'(sync_a), 0);
        chk("async_sync_b", int'(sync_b), 0);
        model_reset();
        repeat (2) @(posedge OSC);
        @(negedge OSC);
        RST_N = 1'b1;
        repeat (12 * PER) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
